universal_shift_reg: RTL and testbench

Parametrised serial/parallel shift register that generalises the 8-bit SIPO to any width. Supports right or left shift, selected per cycle, and synchronous parallel load. Provides a serial output, so it covers SISO, SIPO, PISO and PIPO use in the lab datapaths. A frame counter pulses frame_valid each time WIDTH bits have been shifted in since the last reset, load or frame completion.

---
 rtl/universal_shift_reg.sv | 71 +++++++
 tb/tb_universal_shift_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, left/right serial shift, and a
// frame counter that pulses frame_valid once every WIDTH accepted shifts.
module universal_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             shift,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic             serial_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             frame_valid
);

   // Count value at which the next accepted shift completes a frame.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic             fv;

   // Data register: rst beats load beats shift; otherwise hold.
   always_ff @(posedge clk) begin
      if (rst)
         q <= RESET_VAL;
      else if (load)
         q <= parallel_in;
      else if (shift) begin
         if (dir)
            q <= {q[WIDTH-2:0], serial_in};
         else
            q <= {serial_in, q[WIDTH-1:1]};
      end
   end

   // Frame counter: wraps on the WIDTH-th shift and flags that edge for one
   // cycle; gaps in shift simply hold the count.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= '0;
         fv  <= 1'b0;
      end else if (shift) begin
         if (cnt == LAST_CNT) begin
            cnt <= '0;
            fv  <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
            fv  <= 1'b0;
         end
      end else begin
         fv <= 1'b0;
      end
   end

   // Serial output is the bit that would leave on the next shift in the
   // current direction, so PISO data is visible before the first edge.
   always_comb begin
      serial_out = dir ? q[WIDTH-1] : q[0];
   end

   assign parallel_out = q;
   assign bit_count    = cnt;
   assign frame_valid  = fv;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: an 8-bit and a 5-bit instance share one
// stimulus stream; expected state per edge is queued and checked after it.
module tb_universal_shift_reg;

   logic       clk = 1'b0;
   logic       rst, serial_in, shift, dir, load;
   logic [7:0] parallel_in;
   logic [7:0] po8;
   logic [4:0] po5;
   logic       so8, so5, fv8, fv5;
   logic [2:0] bc8, bc5;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] q;
      int          cnt;
      logic        fv;
   } st_t;

   typedef struct {
      st_t a;
      st_t b;
   } exp_t;

   st_t  m8, m5;
   exp_t sb[$];

   always #5 clk = ~clk;

   universal_shift_reg #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift), .dir(dir),
      .load(load), .parallel_in(parallel_in), .parallel_out(po8),
      .serial_out(so8), .bit_count(bc8), .frame_valid(fv8)
   );

   universal_shift_reg #(.WIDTH(5), .RESET_VAL(5'h1F)) dut5 (
      .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift), .dir(dir),
      .load(load), .parallel_in(parallel_in[4:0]), .parallel_out(po5),
      .serial_out(so5), .bit_count(bc5), .frame_valid(fv5)
   );

   // Reference next-state for a register of width w, from the current inputs.
   function automatic st_t nxt(st_t s, int w, logic [31:0] rv);
      st_t         n;
      logic [31:0] mask;
      mask = (32'h1 << w) - 32'h1;
      n = s;
      if (rst) begin
         n.q = rv; n.cnt = 0; n.fv = 1'b0;
      end else if (load) begin
         n.q = {24'h0, parallel_in} & mask; n.cnt = 0; n.fv = 1'b0;
      end else if (shift) begin
         if (dir)
            n.q = ((s.q << 1) | {31'h0, serial_in}) & mask;
         else
            n.q = (s.q >> 1) | ({31'h0, serial_in} << (w - 1));
         if (s.cnt == w - 1) begin
            n.cnt = 0; n.fv = 1'b1;
         end else begin
            n.cnt = s.cnt + 1; n.fv = 1'b0;
         end
      end else begin
         n.fv = 1'b0;
      end
      return n;
   endfunction

   // One clock edge: push the expectation, let the edge happen, pop and compare.
   task automatic cyc();
      exp_t e;
      logic eso8, eso5;
      e.a = nxt(m8, 8, 32'h00);
      e.b = nxt(m5, 5, 32'h1F);
      m8 = e.a;
      m5 = e.b;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      eso8 = dir ? e.a.q[7] : e.a.q[0];
      eso5 = dir ? e.b.q[4] : e.b.q[0];
      checks++; if (po8 !== e.a.q[7:0]) begin fails++; $display("FAIL sb_q8 got %h exp %h", po8, e.a.q[7:0]); end
      checks++; if (bc8 !== 3'(e.a.cnt)) begin fails++; $display("FAIL sb_cnt8 got %0d exp %0d", bc8, e.a.cnt); end
      checks++; if (fv8 !== e.a.fv) begin fails++; $display("FAIL sb_fv8 got %b exp %b", fv8, e.a.fv); end
      checks++; if (so8 !== eso8) begin fails++; $display("FAIL sb_so8 got %b exp %b", so8, eso8); end
      checks++; if (po5 !== e.b.q[4:0]) begin fails++; $display("FAIL sb_q5 got %h exp %h", po5, e.b.q[4:0]); end
      checks++; if (bc5 !== 3'(e.b.cnt)) begin fails++; $display("FAIL sb_cnt5 got %0d exp %0d", bc5, e.b.cnt); end
      checks++; if (fv5 !== e.b.fv) begin fails++; $display("FAIL sb_fv5 got %b exp %b", fv5, e.b.fv); end
      checks++; if (so5 !== eso5) begin fails++; $display("FAIL sb_so5 got %b exp %b", so5, eso5); end
   endtask

   task automatic test_reset();
      rst = 1'b1; shift = 1'b1; load = 1'b1; parallel_in = 8'hFF; serial_in = 1'b1; dir = 1'b0;
      cyc();
      checks++; if (po8 !== 8'h00) begin fails++; $display("FAIL reset_q8 got %h exp 00", po8); end
      checks++; if (po5 !== 5'h1F) begin fails++; $display("FAIL reset_q5 got %h exp 1f", po5); end
      checks++; if (bc8 !== 3'd0 || bc5 !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0", bc8, bc5); end
      checks++; if (fv8 !== 1'b0 || fv5 !== 1'b0) begin fails++; $display("FAIL reset_fv got %b/%b exp 0", fv8, fv5); end
      rst = 1'b0; load = 1'b0; shift = 1'b0;
   endtask

   task automatic test_shift_right();
      logic [7:0] seq;
      seq = 8'b10110110; // bit i is the i-th bit sent
      dir = 1'b0; shift = 1'b1;
      for (int i = 0; i < 8; i++) begin
         serial_in = seq[i];
         cyc();
         if (i < 7) begin
            checks++; if (fv8 !== 1'b0) begin fails++; $display("FAIL right_early_fv got %b exp 0 at %0d", fv8, i); end
         end
      end
      checks++; if (po8 !== 8'b10110110) begin fails++; $display("FAIL right_q got %b exp 10110110", po8); end
      checks++; if (bc8 !== 3'd0 || fv8 !== 1'b1) begin fails++; $display("FAIL right_frame got cnt %0d fv %b exp 0/1", bc8, fv8); end
      shift = 1'b0;
      cyc();
      checks++; if (fv8 !== 1'b0) begin fails++; $display("FAIL right_pulse_len got %b exp 0", fv8); end
   endtask

   task automatic test_shift_left();
      logic [7:0] seq;
      int         pulses;
      seq = 8'b10110110;
      dir = 1'b1; shift = 1'b1; pulses = 0;
      for (int i = 0; i < 8; i++) begin
         serial_in = seq[i];
         cyc();
         if (fv8) pulses++;
      end
      checks++; if (po8 !== 8'b01101101) begin fails++; $display("FAIL left_q got %b exp 01101101", po8); end
      shift = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (fv8) pulses++;
      end
      checks++; if (pulses != 1) begin fails++; $display("FAIL left_pulses got %0d exp 1", pulses); end
      // 8 more shifts with a 3-cycle gap after the third
      pulses = 0;
      for (int i = 0; i < 11; i++) begin
         shift = !(i >= 3 && i < 6);
         serial_in = 1'($urandom_range(0, 1));
         cyc();
         if (fv8) pulses++;
         if (i == 5) begin
            checks++; if (bc8 !== 3'd3) begin fails++; $display("FAIL gap_hold got %0d exp 3", bc8); end
         end
      end
      checks++; if (pulses != 1 || fv8 !== 1'b1) begin fails++; $display("FAIL gap_frame got %0d pulses fv %b exp 1/1", pulses, fv8); end
      shift = 1'b0;
   endtask

   task automatic test_piso();
      logic [7:0] exp_so;
      exp_so = 8'hA5;
      load = 1'b1; parallel_in = 8'hA5;
      cyc();
      load = 1'b0; dir = 1'b0; shift = 1'b1; serial_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (so8 !== exp_so[i]) begin fails++; $display("FAIL piso_so bit %0d got %b exp %b", i, so8, exp_so[i]); end
         cyc();
      end
      checks++; if (po8 !== 8'h00 || fv8 !== 1'b1) begin fails++; $display("FAIL piso_end got %h fv %b exp 00/1", po8, fv8); end
      shift = 1'b0;
      cyc();
   endtask

   task automatic test_load_priority();
      int pulses;
      dir = 1'b0; shift = 1'b1; serial_in = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      checks++; if (bc8 !== 3'd3) begin fails++; $display("FAIL pre_load_cnt got %0d exp 3", bc8); end
      load = 1'b1; parallel_in = 8'h3C;
      cyc();
      load = 1'b0;
      checks++; if (po8 !== 8'h3C || bc8 !== 3'd0 || fv8 !== 1'b0) begin fails++; $display("FAIL load_prio got %h cnt %0d fv %b exp 3c/0/0", po8, bc8, fv8); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         serial_in = 1'($urandom_range(0, 1));
         cyc();
         if (fv8) pulses++;
         if (i == 6) begin
            checks++; if (pulses != 0) begin fails++; $display("FAIL load_early_pulse got %0d exp 0", pulses); end
         end
      end
      checks++; if (fv8 !== 1'b1) begin fails++; $display("FAIL load_frame got %b exp 1", fv8); end
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++; if (po8 !== 8'h00 || bc8 !== 3'd0 || fv8 !== 1'b0) begin fails++; $display("FAIL mid_rst got %h cnt %0d fv %b exp 00/0/0", po8, bc8, fv8); end
      checks++; if (po5 !== 5'h1F || bc5 !== 3'd0) begin fails++; $display("FAIL mid_rst5 got %h cnt %0d exp 1f/0", po5, bc5); end
      shift = 1'b0;
   endtask

   task automatic test_w5();
      logic [4:0] seq;
      logic [4:0] exp_so;
      seq = 5'b10110;
      rst = 1'b1; cyc(); rst = 1'b0;
      dir = 1'b0; shift = 1'b1;
      for (int i = 0; i < 5; i++) begin
         serial_in = seq[i];
         cyc();
         checks++; if (bc5 !== 3'((i + 1) % 5)) begin fails++; $display("FAIL w5_cnt got %0d exp %0d", bc5, (i + 1) % 5); end
      end
      checks++; if (po5 !== 5'b10110 || fv5 !== 1'b1) begin fails++; $display("FAIL w5_frame got %b fv %b exp 10110/1", po5, fv5); end
      load = 1'b1; parallel_in = 8'hA5;
      cyc();
      load = 1'b0; serial_in = 1'b0;
      exp_so = 5'b00101;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (so5 !== exp_so[i]) begin fails++; $display("FAIL w5_so bit %0d got %b exp %b", i, so5, exp_so[i]); end
         cyc();
      end
      checks++; if (po5 !== 5'h00 || fv5 !== 1'b1) begin fails++; $display("FAIL w5_piso got %h fv %b exp 00/1", po5, fv5); end
      shift = 1'b0;
   endtask

   task automatic test_back_to_back();
      int p8, p5;
      rst = 1'b1; cyc(); rst = 1'b0;
      shift = 1'b1; p8 = 0; p5 = 0;
      for (int i = 0; i < 40; i++) begin
         dir = 1'($urandom_range(0, 1));
         serial_in = 1'($urandom_range(0, 1));
         cyc();
         if (fv8) p8++;
         if (fv5) p5++;
      end
      checks++; if (p8 != 5 || p5 != 8) begin fails++; $display("FAIL b2b_pulses got %0d/%0d exp 5/8", p8, p5); end
      shift = 1'b0;
      cyc();
   endtask

   initial begin
      m8 = '{q: 32'h0, cnt: 0, fv: 1'b0};
      m5 = '{q: 32'h0, cnt: 0, fv: 1'b0};
      rst = 1'b1; serial_in = 1'b0; shift = 1'b0; dir = 1'b0; load = 1'b0; parallel_in = 8'h00;
      @(negedge clk);
      test_reset();
      test_shift_right();
      test_shift_left();
      test_piso();
      test_load_priority();
      test_w5();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
